// File: rtl/key_debounce.sv
// Debounced push-button: 2-flop synchronizer, four-state debounce FSM, registered pulses/levels.
// Optional long-press detection is compiled in when LONG_PRESS_EN is defined.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          INV_BTN         = 1'b0,
  parameter int unsigned LONG_CYCLES     = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic key_o,
  output logic press_o,
  output logic release_o,
  output logic toggle_o,
  output logic long_o
);

  localparam logic [15:0] CntLast = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StReleased,
    StPressCheck,
    StPressed,
    StReleaseCheck
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sync1_q, sync2_q;
  logic        key_s;
  logic        key_q, key_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        toggle_q, toggle_d;

  // Synchronizer resets to the idle pin level so key_s reads 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= INV_BTN;
      sync2_q <= INV_BTN;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = sync2_q ^ INV_BTN;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      StReleased: begin
        if (key_s) begin
          state_d = StPressCheck;
          cnt_d   = '0;
        end
      end
      StPressCheck: begin
        if (!key_s) begin
          state_d = StReleased;
        end else if (cnt_q == CntLast) begin
          state_d = StPressed;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StPressed: begin
        if (!key_s) begin
          state_d = StReleaseCheck;
          cnt_d   = '0;
        end
      end
      StReleaseCheck: begin
        if (key_s) begin
          state_d = StPressed;
        end else if (cnt_q == CntLast) begin
          state_d   = StReleased;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StReleased;
    endcase
    key_d    = (state_d == StPressed) || (state_d == StReleaseCheck);
    toggle_d = toggle_q ^ press_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StReleased;
      cnt_q     <= '0;
      key_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign key_o     = key_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign toggle_o  = toggle_q;

`ifdef LONG_PRESS_EN
  localparam logic [31:0] HoldMax  = 32'(LONG_CYCLES);
  localparam logic [31:0] HoldLast = 32'(LONG_CYCLES - 1);

  logic [31:0] hold_q, hold_d;
  logic        long_q, long_d;

  // Only a fresh press clears the count; a release glitch back to StPressed keeps it.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (press_d) begin
      hold_d = '0;
    end else if (((state_q == StPressed) || (state_q == StReleaseCheck)) &&
                 (hold_q < HoldMax)) begin
      hold_d = hold_q + 32'd1;
      long_d = (hold_d == HoldLast);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// A second instance with INV_BTN=1 covers the active-low button.
module tb_key_debounce;

  logic clk;
  logic rst;
  logic key;
  logic key_o, press_o, release_o, toggle_o, long_o;
  logic key_inv;
  logic ikey_o, ipress_o, irelease_o, itoggle_o, ilong_o;

  int n_vec;
  int n_err;
  int press_cnt, release_cnt, long_cnt, both_cnt;
  int n;

  key_debounce #(
    .DEBOUNCE_CYCLES(4),
    .INV_BTN        (1'b0),
    .LONG_CYCLES    (20)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .key_i    (key),
    .key_o    (key_o),
    .press_o  (press_o),
    .release_o(release_o),
    .toggle_o (toggle_o),
    .long_o   (long_o)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(4),
    .INV_BTN        (1'b1),
    .LONG_CYCLES    (20)
  ) u_dut_inv (
    .clk      (clk),
    .rst      (rst),
    .key_i    (key_inv),
    .key_o    (ikey_o),
    .press_o  (ipress_o),
    .release_o(irelease_o),
    .toggle_o (itoggle_o),
    .long_o   (ilong_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (!rst) begin
      press_cnt   <= press_cnt + int'(press_o);
      release_cnt <= release_cnt + int'(release_o);
      long_cnt    <= long_cnt + int'(long_o);
      both_cnt    <= both_cnt + int'(press_o & release_o);
    end
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges until the selected output is high; -1 if the budget runs out.
  task automatic wait_edge(input int sel, input int budget, output int edges);
    logic s;
    edges = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      case (sel)
        0:       s = press_o;
        1:       s = release_o;
        2:       s = long_o;
        default: s = ipress_o;
      endcase
      if (s) begin
        edges = i;
        return;
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    press_cnt = 0; release_cnt = 0; long_cnt = 0; both_cnt = 0;
    rst = 1'b1;
    key = 1'b0;
    key_inv = 1'b1;
    repeat (3) tick();
    check("rst_key", 32'(key_o), 0);
    check("rst_press", 32'(press_o), 0);
    check("rst_release", 32'(release_o), 0);
    check("rst_toggle", 32'(toggle_o), 0);
    check("rst_long", 32'(long_o), 0);
    check("rst_inv_key", 32'(ikey_o), 0);

    rst = 1'b0;
    repeat (10) tick();
    check("inv_idle_key", 32'(ikey_o), 0);
    check("inv_idle_toggle", 32'(itoggle_o), 0);

    // Bounce of 3 cycles must be rejected.
    key = 1'b1;
    repeat (3) tick();
    key = 1'b0;
    repeat (15) tick();
    check("bounce_key", 32'(key_o), 0);
    check("bounce_toggle", 32'(toggle_o), 0);
    check("bounce_press_cnt", 32'(press_cnt), 0);

    // First clean press.
    key = 1'b1;
    wait_edge(0, 30, n);
    check("press1_lat", 32'(n), 7);
    check("press1_key", 32'(key_o), 1);
    check("press1_toggle", 32'(toggle_o), 1);
    tick();
    check("press1_width", 32'(press_o), 0);

    // Hold for 50 cycles after the press pulse.
`ifdef LONG_PRESS_EN
    wait_edge(2, 49, n);
    check("long_lat", 32'(n), 18);
    repeat (50 - 1 - n) tick();
    check("long_cnt", 32'(long_cnt), 1);
`else
    wait_edge(2, 49, n);
    check("long_absent", 32'(n), -1);
    check("long_cnt", 32'(long_cnt), 0);
`endif

    key = 1'b0;
    wait_edge(1, 30, n);
    check("release1_lat", 32'(n), 7);
    check("release1_key", 32'(key_o), 0);
    check("release1_toggle", 32'(toggle_o), 1);

    // Second press/release brings toggle back to 0.
    repeat (5) tick();
    key = 1'b1;
    wait_edge(0, 30, n);
    check("press2_lat", 32'(n), 7);
    check("press2_toggle", 32'(toggle_o), 0);
    repeat (5) tick();
    key = 1'b0;
    wait_edge(1, 30, n);
    check("release2_lat", 32'(n), 7);
    repeat (3) tick();
    check("press_cnt", 32'(press_cnt), 2);
    check("release_cnt", 32'(release_cnt), 2);
    check("both_high_cnt", 32'(both_cnt), 0);

    // Active-low instance.
    key_inv = 1'b0;
    wait_edge(3, 30, n);
    check("inv_press_lat", 32'(n), 7);
    check("inv_key", 32'(ikey_o), 1);
    check("inv_toggle", 32'(itoggle_o), 1);

    // Reset in the middle of press debounce, key held through it.
    key = 1'b1;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_inv_key", 32'(ikey_o), 0);
    check("arst_inv_toggle", 32'(itoggle_o), 0);
    check("arst_key", 32'(key_o), 0);
    check("arst_press", 32'(press_o), 0);
    tick();
    rst = 1'b0;
    wait_edge(0, 30, n);
    check("post_rst_press_lat", 32'(n), 7);
    check("post_rst_key", 32'(key_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
